// File: rtl/cp0_nway.sv
// N-way CP0: Status/Cause/EPC/BadVAddr, precise oldest-way exception select, ERET redirect.
// Define CP0_TIMER_EN to build the Count/Compare timer; otherwise TI and timer_int_o are tied to 0.
module cp0_nway #(
    parameter int unsigned ISSUE_W = 2,
    parameter logic [31:0] EXC_VEC = 32'hBFC0_0380
) (
    input  logic                   clk,
    input  logic                   rst_,
    input  logic                   ex_cp0_re,
    input  logic [5*ISSUE_W-1:0]   ex_cp0_raddr,
    output logic [32*ISSUE_W-1:0]  ex_cp0_rdata,
    input  logic [ISSUE_W-1:0]     wb_cp0_we,
    input  logic [5*ISSUE_W-1:0]   wb_cp0_waddr,
    input  logic [32*ISSUE_W-1:0]  wb_cp0_wdata,
    input  logic [5:0]             int_i,
    input  logic [32*ISSUE_W-1:0]  ex_cp0_exc_pc_i,
    input  logic [ISSUE_W-1:0]     ex_cp0_in_delay_i,
    input  logic [5*ISSUE_W-1:0]   ex_cp0_exc_code_i,
    input  logic [32*ISSUE_W-1:0]  ex_cp0_badvaddr_i,
    output logic                   exc_flush_all,
    output logic                   exc_flush_icache,
    output logic [31:0]            cp0_if_excaddr,
    output logic                   timer_int_o
);

    localparam logic [4:0] EXC_INT  = 5'h00;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;
    localparam logic [4:0] EXC_NONE = 5'h10;
    localparam logic [4:0] EXC_ERET = 5'h11;

    localparam logic [4:0] ADDR_BADVADDR = 5'd8;
    localparam logic [4:0] ADDR_COUNT    = 5'd9;
    localparam logic [4:0] ADDR_COMPARE  = 5'd11;
    localparam logic [4:0] ADDR_STATUS   = 5'd12;
    localparam logic [4:0] ADDR_CAUSE    = 5'd13;
    localparam logic [4:0] ADDR_EPC      = 5'd14;

    localparam logic [31:0] STATUS_RST   = 32'h0040_0000;
    localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;

    logic [31:0] status, cause, epc, badvaddr;
    logic [31:0] status_n, cause_n, epc_n, badvaddr_n;
    logic        flush_icache;
    logic        ti_n;

    logic        status_we, cause_we, epc_we;
    logic [31:0] status_wd, epc_wd;
    logic [1:0]  cause_ip_wd;

    logic        found, sel_delay;
    logic [4:0]  sel_code;
    logic [31:0] sel_pc, sel_bva;
    logic        int_pend;
    logic [31:0] eret_target;

`ifdef CP0_TIMER_EN
    logic [31:0] count, compare, count_inc, count_wd, compare_wd;
    logic        toggle, count_we, compare_we;
`endif

    assign int_pend = (|(status[15:8] & cause[15:8])) & status[0] & ~status[1];

    // Way 0 is oldest: the first way with a live code wins; a pending interrupt replaces way 0's code.
    always_comb begin : exc_select
        logic [4:0] code;
        code      = EXC_NONE;
        found     = 1'b0;
        sel_code  = EXC_NONE;
        sel_pc    = '0;
        sel_delay = 1'b0;
        sel_bva   = '0;
        for (int unsigned i = 0; i < ISSUE_W; i++) begin
            code = ex_cp0_exc_code_i[i*5 +: 5];
            if (i == 0 && int_pend)
                code = EXC_INT;
            if (!found && code != EXC_NONE) begin
                found     = 1'b1;
                sel_code  = code;
                sel_pc    = ex_cp0_exc_pc_i[i*32 +: 32];
                sel_delay = ex_cp0_in_delay_i[i];
                sel_bva   = ex_cp0_badvaddr_i[i*32 +: 32];
            end
        end
    end

    // Ascending scan: the youngest writer of a register overrides older ones.
    always_comb begin : mtc0_collect
        status_we   = 1'b0;
        status_wd   = '0;
        cause_we    = 1'b0;
        cause_ip_wd = '0;
        epc_we      = 1'b0;
        epc_wd      = '0;
`ifdef CP0_TIMER_EN
        count_we    = 1'b0;
        count_wd    = '0;
        compare_we  = 1'b0;
        compare_wd  = '0;
`endif
        for (int unsigned i = 0; i < ISSUE_W; i++) begin
            if (wb_cp0_we[i]) begin
                case (wb_cp0_waddr[i*5 +: 5])
                    ADDR_STATUS: begin
                        status_we = 1'b1;
                        status_wd = wb_cp0_wdata[i*32 +: 32];
                    end
                    ADDR_CAUSE: begin
                        cause_we    = 1'b1;
                        cause_ip_wd = wb_cp0_wdata[i*32+8 +: 2];
                    end
                    ADDR_EPC: begin
                        epc_we = 1'b1;
                        epc_wd = wb_cp0_wdata[i*32 +: 32];
                    end
`ifdef CP0_TIMER_EN
                    ADDR_COUNT: begin
                        count_we = 1'b1;
                        count_wd = wb_cp0_wdata[i*32 +: 32];
                    end
                    ADDR_COMPARE: begin
                        compare_we = 1'b1;
                        compare_wd = wb_cp0_wdata[i*32 +: 32];
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

    always_comb begin : mfc0_read
        ex_cp0_rdata = '0;
        for (int unsigned i = 0; i < ISSUE_W; i++) begin
            if (ex_cp0_re && rst_) begin
                case (ex_cp0_raddr[i*5 +: 5])
                    ADDR_BADVADDR: ex_cp0_rdata[i*32 +: 32] = badvaddr;
`ifdef CP0_TIMER_EN
                    ADDR_COUNT:    ex_cp0_rdata[i*32 +: 32] = count;
                    ADDR_COMPARE:  ex_cp0_rdata[i*32 +: 32] = compare;
`endif
                    ADDR_STATUS:   ex_cp0_rdata[i*32 +: 32] = status;
                    ADDR_CAUSE:    ex_cp0_rdata[i*32 +: 32] = cause;
                    ADDR_EPC:      ex_cp0_rdata[i*32 +: 32] = epc;
                    default:       ex_cp0_rdata[i*32 +: 32] = '0;
                endcase
            end
        end
    end

    assign eret_target      = epc_we ? epc_wd : epc;
    assign exc_flush_all    = found & rst_;
    assign cp0_if_excaddr   = !exc_flush_all ? '0 :
                              (sel_code == EXC_ERET) ? eret_target : EXC_VEC;
    assign exc_flush_icache = flush_icache;
    assign timer_int_o      = cause[30];

`ifdef CP0_TIMER_EN
    always_comb begin : timer_match
        count_inc = count + 32'd1;
        ti_n      = cause[30];
        if (toggle && !count_we && count_inc == compare)
            ti_n = 1'b1;
        if (compare_we)
            ti_n = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            count   <= '0;
            compare <= '0;
            toggle  <= 1'b0;
        end else begin
            if (count_we) begin
                count  <= count_wd;
                toggle <= 1'b0;
            end else begin
                toggle <= ~toggle;
                if (toggle)
                    count <= count_inc;
            end
            if (compare_we)
                compare <= compare_wd;
        end
    end
`else
    assign ti_n = 1'b0;
`endif

    // MTC0 results are applied first so exception-owned fields overwrite them afterwards.
    always_comb begin : next_state
        status_n = status;
        if (status_we)
            status_n = (status & ~STATUS_WMASK) | (status_wd & STATUS_WMASK);
        cause_n        = cause;
        cause_n[15:10] = {int_i[5] | cause[30], int_i[4:0]};
        cause_n[30]    = ti_n;
        if (cause_we)
            cause_n[9:8] = cause_ip_wd;
        epc_n      = epc_we ? epc_wd : epc;
        badvaddr_n = badvaddr;
        if (found) begin
            if (sel_code == EXC_ERET) begin
                status_n[1] = 1'b0;
            end else begin
                if (!status[1]) begin
                    epc_n       = sel_delay ? sel_pc - 32'd4 : sel_pc;
                    cause_n[31] = sel_delay;
                end
                status_n[1]   = 1'b1;
                cause_n[6:2]  = sel_code;
                if (sel_code == EXC_ADEL || sel_code == EXC_ADES)
                    badvaddr_n = sel_bva;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            status       <= STATUS_RST;
            cause        <= '0;
            epc          <= '0;
            badvaddr     <= '0;
            flush_icache <= 1'b0;
        end else begin
            status       <= status_n;
            cause        <= cause_n;
            epc          <= epc_n;
            badvaddr     <= badvaddr_n;
            flush_icache <= found;
        end
    end

endmodule

// File: tb/tb_cp0_nway.sv
// Directed self-checking bench for cp0_nway (ISSUE_W=2); timer checks depend on CP0_TIMER_EN.
module tb_cp0_nway;

    localparam int unsigned W = 2;
    localparam logic [31:0] VEC = 32'hBFC0_0380;

    logic              clk = 1'b0;
    logic              rst_ = 1'b0;
    logic              ex_cp0_re;
    logic [5*W-1:0]    ex_cp0_raddr;
    logic [32*W-1:0]   ex_cp0_rdata;
    logic [W-1:0]      wb_cp0_we;
    logic [5*W-1:0]    wb_cp0_waddr;
    logic [32*W-1:0]   wb_cp0_wdata;
    logic [5:0]        int_i;
    logic [32*W-1:0]   ex_cp0_exc_pc_i;
    logic [W-1:0]      ex_cp0_in_delay_i;
    logic [5*W-1:0]    ex_cp0_exc_code_i;
    logic [32*W-1:0]   ex_cp0_badvaddr_i;
    logic              exc_flush_all;
    logic              exc_flush_icache;
    logic [31:0]       cp0_if_excaddr;
    logic              timer_int_o;

    int checks = 0;
    int errors = 0;

    cp0_nway #(.ISSUE_W(W), .EXC_VEC(VEC)) dut (
        .clk               (clk),
        .rst_              (rst_),
        .ex_cp0_re         (ex_cp0_re),
        .ex_cp0_raddr      (ex_cp0_raddr),
        .ex_cp0_rdata      (ex_cp0_rdata),
        .wb_cp0_we         (wb_cp0_we),
        .wb_cp0_waddr      (wb_cp0_waddr),
        .wb_cp0_wdata      (wb_cp0_wdata),
        .int_i             (int_i),
        .ex_cp0_exc_pc_i   (ex_cp0_exc_pc_i),
        .ex_cp0_in_delay_i (ex_cp0_in_delay_i),
        .ex_cp0_exc_code_i (ex_cp0_exc_code_i),
        .ex_cp0_badvaddr_i (ex_cp0_badvaddr_i),
        .exc_flush_all     (exc_flush_all),
        .exc_flush_icache  (exc_flush_icache),
        .cp0_if_excaddr    (cp0_if_excaddr),
        .timer_int_o       (timer_int_o)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        wb_cp0_we         = '0;
        wb_cp0_waddr      = '0;
        wb_cp0_wdata      = '0;
        ex_cp0_exc_code_i = {5'h10, 5'h10};
        ex_cp0_in_delay_i = '0;
        ex_cp0_exc_pc_i   = '0;
        ex_cp0_badvaddr_i = '0;
    endtask

    task automatic exc(input int w, input logic [4:0] code, input logic [31:0] pc,
                       input logic dly, input logic [31:0] bva);
        ex_cp0_exc_code_i[w*5 +: 5]  = code;
        ex_cp0_exc_pc_i[w*32 +: 32]  = pc;
        ex_cp0_in_delay_i[w]         = dly;
        ex_cp0_badvaddr_i[w*32 +: 32] = bva;
    endtask

    task automatic wr(input int w, input logic [4:0] a, input logic [31:0] d);
        wb_cp0_we[w]             = 1'b1;
        wb_cp0_waddr[w*5 +: 5]   = a;
        wb_cp0_wdata[w*32 +: 32] = d;
    endtask

    task automatic rd(input string tag, input int w, input logic [4:0] a, input logic [31:0] exp);
        ex_cp0_re              = 1'b1;
        ex_cp0_raddr[w*5 +: 5] = a;
        #1;
        chk(tag, ex_cp0_rdata[w*32 +: 32], exp);
        ex_cp0_re = 1'b0;
    endtask

    initial begin
        ex_cp0_re    = 1'b0;
        ex_cp0_raddr = '0;
        int_i        = '0;
        clr();

        // reset state
        cyc();
        cyc();
        chk("rst_flush", {31'd0, exc_flush_all}, 32'd0);
        chk("rst_excaddr", cp0_if_excaddr, 32'd0);
        rst_ = 1'b1;
        #1;
        rd("rst_status", 0, 5'd12, 32'h0040_0000);
        rd("rst_cause", 1, 5'd13, 32'h0);
        rd("rst_epc", 0, 5'd14, 32'h0);
        rd("unmapped", 1, 5'd3, 32'h0);
        ex_cp0_raddr = {5'd12, 5'd12};
        #1;
        chk("re_off", ex_cp0_rdata[31:0], 32'h0);
        chk("rst_icache", {31'd0, exc_flush_icache}, 32'd0);

        // way 1 SYS in a delay slot
        cyc();
        exc(1, 5'h08, 32'hBFC0_0104, 1'b1, 32'h0);
        #1;
        chk("sys_flush", {31'd0, exc_flush_all}, 32'd1);
        chk("sys_addr", cp0_if_excaddr, VEC);
        cyc();
        chk("sys_icache", {31'd0, exc_flush_icache}, 32'd1);
        clr();
        rd("sys_epc", 0, 5'd14, 32'hBFC0_0100);
        rd("sys_cause", 0, 5'd13, 32'h8000_0020);
        rd("sys_status", 1, 5'd12, 32'h0040_0002);
        cyc();
        chk("icache_drop", {31'd0, exc_flush_icache}, 32'd0);

        // way 0 OV beats way 1 ADEL; EXL=1 keeps EPC/BD
        exc(0, 5'h0C, 32'h8000_0010, 1'b0, 32'h0);
        exc(1, 5'h04, 32'h8000_0014, 1'b0, 32'h1234_5678);
        #1;
        chk("ov_flush", {31'd0, exc_flush_all}, 32'd1);
        chk("ov_addr", cp0_if_excaddr, VEC);
        cyc();
        clr();
        rd("ov_cause", 0, 5'd13, 32'h8000_0030);
        rd("ov_bva", 0, 5'd8, 32'h0);
        rd("ov_epc", 1, 5'd14, 32'hBFC0_0100);

        // way 1 ADES alone loads BadVAddr
        exc(1, 5'h05, 32'h8000_0020, 1'b0, 32'hDEAD_BEEC);
        cyc();
        clr();
        rd("ades_bva", 0, 5'd8, 32'hDEAD_BEEC);
        rd("ades_cause", 1, 5'd13, 32'h8000_0014);

        // both ways write Status: youngest wins
        wr(0, 5'd12, 32'hFFFF_FFFF);
        wr(1, 5'd12, 32'h0000_0002);
        #1;
        chk("wr_noflush", {31'd0, exc_flush_all}, 32'd0);
        cyc();
        clr();
        rd("status_youngest", 0, 5'd12, 32'h0040_0002);

        // Cause write mask and read-only BadVAddr
        wr(0, 5'd13, 32'hFFFF_FFFF);
        wr(1, 5'd8, 32'h1111_1111);
        cyc();
        clr();
        rd("cause_mask", 0, 5'd13, 32'h8000_0314);
        rd("bva_ro", 1, 5'd8, 32'hDEAD_BEEC);
        wr(0, 5'd13, 32'h0);
        cyc();
        clr();
        rd("cause_clr", 0, 5'd13, 32'h8000_0014);

        // ERET with same-cycle EPC writes on both ways
        exc(0, 5'h11, 32'h8000_0100, 1'b0, 32'h0);
        wr(0, 5'd14, 32'h1111_0000);
        wr(1, 5'd14, 32'h8000_1234);
        #1;
        chk("eret_flush", {31'd0, exc_flush_all}, 32'd1);
        chk("eret_addr", cp0_if_excaddr, 32'h8000_1234);
        cyc();
        clr();
        rd("eret_status", 0, 5'd12, 32'h0040_0000);
        rd("eret_epc", 1, 5'd14, 32'h8000_1234);

        // exception beats a same-cycle MTC0 to EPC
        exc(0, 5'h08, 32'h8000_0200, 1'b0, 32'h0);
        wr(1, 5'd14, 32'h5555_5554);
        cyc();
        clr();
        rd("excw_epc", 0, 5'd14, 32'h8000_0200);
        rd("excw_cause", 0, 5'd13, 32'h0000_0020);
        rd("excw_status", 1, 5'd12, 32'h0040_0002);

        // hardware interrupt 0 overrides way 0's code
        wr(0, 5'd12, 32'h0000_FF01);
        int_i = 6'b000001;
        #1;
        chk("int_pre", {31'd0, exc_flush_all}, 32'd0);
        cyc();
        clr();
        rd("int_ip2", 0, 5'd13, 32'h0000_0420);
        rd("int_status", 0, 5'd12, 32'h0040_FF01);
        chk("int_flush_none", {31'd0, exc_flush_all}, 32'd1);
        exc(0, 5'h0A, 32'h8000_0300, 1'b0, 32'h0);
        exc(1, 5'h09, 32'h8000_0304, 1'b0, 32'h0);
        #1;
        chk("int_addr", cp0_if_excaddr, VEC);
        cyc();
        clr();
        int_i = '0;
        rd("int_cause", 0, 5'd13, 32'h0000_0400);
        rd("int_epc", 1, 5'd14, 32'h8000_0300);
        chk("int_masked", {31'd0, exc_flush_all}, 32'd0);

`ifdef CP0_TIMER_EN
        wr(0, 5'd9, 32'h0);
        wr(1, 5'd11, 32'd5);
        cyc();
        clr();
        chk("ti_start", {31'd0, timer_int_o}, 32'd0);
        repeat (9) cyc();
        chk("ti_early", {31'd0, timer_int_o}, 32'd0);
        cyc();
        chk("ti_set", {31'd0, timer_int_o}, 32'd1);
        rd("ti_count", 0, 5'd9, 32'd5);
        wr(1, 5'd11, 32'd7);
        cyc();
        clr();
        chk("ti_clear", {31'd0, timer_int_o}, 32'd0);
`else
        wr(0, 5'd9, 32'h0000_1234);
        wr(1, 5'd11, 32'h0000_0055);
        cyc();
        clr();
        rd("no_count", 0, 5'd9, 32'h0);
        rd("no_compare", 1, 5'd11, 32'h0);
        chk("no_ti", {31'd0, timer_int_o}, 32'd0);
`endif

        // async reset in the middle of a flush
        exc(0, 5'h08, 32'h8000_0400, 1'b0, 32'h0);
        cyc();
        chk("mid_icache", {31'd0, exc_flush_icache}, 32'd1);
        chk("mid_flush", {31'd0, exc_flush_all}, 32'd1);
        #2;
        rst_ = 1'b0;
        ex_cp0_re    = 1'b1;
        ex_cp0_raddr = {5'd12, 5'd12};
        #1;
        chk("ar_flush", {31'd0, exc_flush_all}, 32'd0);
        chk("ar_icache", {31'd0, exc_flush_icache}, 32'd0);
        chk("ar_addr", cp0_if_excaddr, 32'h0);
        chk("ar_rdata", ex_cp0_rdata[31:0], 32'h0);
        ex_cp0_re = 1'b0;
        cyc();
        clr();
        rst_ = 1'b1;
        #1;
        rd("ar_status", 0, 5'd12, 32'h0040_0000);
        rd("ar_epc", 1, 5'd14, 32'h0);
        chk("ar_noflush", {31'd0, exc_flush_all}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cp0_nway.md
Name: cp0_nway

Overview:
- Parametrised CP0 for the N-issue MIPS pipeline; generalises the dual-issue CP0 to ISSUE_W ways.
- Adds a Count/Compare timer, Status.IM interrupt masking and BadVAddr capture on address errors.
- Adds per-way MTC0 enables and per-way precise exception selection (oldest way wins).
- Sits beside EX (MFC0 read, exception resolve) and WB (MTC0 commit); drives pipeline flush and the IF redirect address.

Parameters:
ISSUE_W, 2, number of issue ways; way 0 is oldest in program order
EXC_VEC, 32'hBFC00380, entry PC for all non-ERET exceptions and interrupts

Ports:
clk  in  1  clock
rst_  in  1  asynchronous active-low reset
ex_cp0_re  in  1  MFC0 read enable
ex_cp0_raddr  in  5*ISSUE_W  per-way CP0 read address
ex_cp0_rdata  out  32*ISSUE_W  per-way read data
wb_cp0_we  in  ISSUE_W  per-way MTC0 write enable
wb_cp0_waddr  in  5*ISSUE_W  per-way write address
wb_cp0_wdata  in  32*ISSUE_W  per-way write data
int_i  in  6  external hardware interrupts, level-sensitive
ex_cp0_exc_pc_i  in  32*ISSUE_W  per-way PC
ex_cp0_in_delay_i  in  ISSUE_W  per-way branch-delay-slot flag
ex_cp0_exc_code_i  in  5*ISSUE_W  per-way exception code
ex_cp0_badvaddr_i  in  32*ISSUE_W  per-way faulting address (ADEL/ADES)
exc_flush_all  out  1  flush all stages, combinational
exc_flush_icache  out  1  exc_flush_all delayed one cycle
cp0_if_excaddr  out  32  redirect PC, valid while exc_flush_all=1
timer_int_o  out  1  Cause.TI

Behaviour:
- Exception codes: INT 00, ADEL 04, ADES 05, SYS 08, BP 09, RI 0A, OV 0C, NONE 10, ERET 11.
- Registers and addresses: BadVAddr 8, Count 9, Compare 11, Status 12, Cause 13, EPC 14. Unmapped addresses read 0.
- Reset values: all registers 0 except Status = 32'h0040_0000 (BEV). exc_flush_icache = 0. Combinational outputs are 0 while rst_=0.
- Reads: combinational, per way; return 0 when ex_cp0_re=0.
- Interrupt pending: int_pend = |(Status[15:8] & Cause[15:8]) & Status[0] & ~Status[1]. When set, it overrides way 0's code with INT.
- Exception select: the lowest way index whose effective code != NONE. exc_flush_all = 1 iff such a way exists.
- ERET: clears Status.EXL. Redirect = EPC; a same-cycle WB write to EPC is bypassed, highest way index wins.
- Other exceptions: redirect = EXC_VEC.
  - If EXL=0: EPC = in_delay ? pc-4 : pc, and Cause.BD = in_delay. If EXL=1: EPC and BD are unchanged.
  - EXL set to 1; Cause[6:2] = selected code.
  - ADEL/ADES also load BadVAddr from the selected way's ex_cp0_badvaddr_i.
- MTC0 commits every cycle, including exception cycles.
  - Multiple ways writing the same register: the highest index (youngest) wins.
  - Fields updated by an exception in the same cycle take the exception value.
- Write masks:
  - Status: only IM[15:8], EXL[1], IE[0] are writable.
  - Cause: only IP[9:8] (software interrupts) are writable.
  - BadVAddr: read-only.
- Cause.IP[15:10] is registered every cycle from int_i; IP7 = int_i[5] | TI.
- Timer:
  - A toggle bit flips every cycle; Count increments when toggle=1, wrapping 32'hFFFFFFFF -> 0.
  - An MTC0 to Count loads the value and clears the toggle.
  - When the incremented Count equals Compare, TI is set and held.
  - An MTC0 to Compare clears TI; if a match occurs in the same cycle, the clear wins.
- Async reset mid-exception: all state returns to reset values immediately; no flush persists.

Optional Feature:
CP0_TIMER_EN
- Defined: Count, Compare and TI are implemented as above.
- Undefined: the registers are absent, reads of addresses 9 and 11 return 0, writes to them are ignored, TI and timer_int_o are tied to 0.

Test Plan:
- Way 1 SYS at pc 0xBFC00104, way 0 NONE, in_delay=2'b10 -> exc_flush_all=1, redirect 0xBFC00380, EPC=0xBFC00100, Cause=0x8000_0020, Status.EXL=1; exc_flush_icache=1 the next cycle.
- Way 0 OV and way 1 ADEL in the same cycle -> way 0 selected; ExcCode=0C; BadVAddr unchanged.
- ERET on way 0 while way 1 WB writes EPC=0x8000_1234 -> redirect 0x8000_1234; EXL cleared; EPC=0x8000_1234 the next cycle.
- Status=0x0000_FF01, int_i=6'b000001 -> one cycle later Cause.IP2=1; the next EX cycle flushes with ExcCode=00 on way 0, whatever way 0's own code.
- With CP0_TIMER_EN: Compare=5, Count=0 -> TI=1 after 10 cycles and timer_int_o=1; an MTC0 to Compare clears it. Without the macro: reading address 9 returns 0.
- Drop rst_ asynchronously mid-flush -> outputs zero immediately and Status reads 0x0040_0000.
